// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between icache fetch and dcache data requesters.
// Data wins by default; a starvation counter forces a fetch grant after STARVE_LIMIT data grants.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_done,
  input  logic                d_req,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W/8-1:0] d_we,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_done,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [DATA_W-1:0]   mem_din,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_dout,
  output logic                busy
);
  localparam int BE_W = DATA_W / 8;
  localparam int CW   = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   we;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  state_t        state, state_nxt;
  mem_req_t      req_q, req_win;
  logic          gnt_i;
  logic [CW-1:0] starve_cnt;
  logic          pick_i, grant_now, resp_now;

  assign grant_now = (state == IDLE) && (i_req || d_req);
  assign pick_i    = i_req && (!d_req || starve_cnt >= LIM);
  assign resp_now  = (state == RESP) && mem_resp_valid;

  always_comb begin
    req_win.addr  = d_addr;
    req_win.we    = d_we;
    req_win.wdata = d_wdata;
    if (pick_i) begin
      req_win.addr  = i_addr;
      req_win.we    = '0;
      req_win.wdata = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_req || d_req)  state_nxt = REQ;
      REQ:     if (mem_req_ready)   state_nxt = RESP;
      RESP:    if (mem_resp_valid)  state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  // Payload, grant owner and starvation count only move at grant time
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q      <= '0;
      gnt_i      <= 1'b0;
      starve_cnt <= '0;
    end else if (grant_now) begin
      req_q <= req_win;
      gnt_i <= pick_i;
      if (!pick_i && i_req)
        starve_cnt <= (starve_cnt >= LIM) ? LIM : starve_cnt + 1'b1;
      else
        starve_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_done  <= 1'b0;
      d_done  <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
    end else begin
      i_done <= resp_now && gnt_i;
      d_done <= resp_now && !gnt_i;
      if (resp_now && gnt_i) i_rdata <= mem_dout;
      // Writes also get a response, but must not disturb the held read data
      if (resp_now && !gnt_i && req_q.we == '0) d_rdata <= mem_dout;
    end
  end

  assign mem_req_valid = (state == REQ);
  assign busy          = (state != IDLE);
  assign mem_addr      = req_q.addr;
  assign mem_we        = req_q.we;
  assign mem_din       = req_q.wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random requester/memory traffic against a transaction-level model of the arbiter,
// plus forced starvation traffic and resets landing while a response is pending.
module tb_mem_port_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BW  = DW / 8;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, d_req, mem_req_ready, mem_resp_valid;
  logic [AW-1:0] i_addr, d_addr;
  logic [BW-1:0] d_we;
  logic [DW-1:0] d_wdata, mem_dout;
  logic [DW-1:0] i_rdata, d_rdata, mem_din;
  logic          i_done, d_done, mem_req_valid, busy;
  logic [AW-1:0] mem_addr;
  logic [BW-1:0] mem_we;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din),
    .mem_resp_valid(mem_resp_valid), .mem_dout(mem_dout), .busy(busy)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Transaction view: one open transaction, either waiting for acceptance or for its response
  bit            m_txn, m_acc, m_own_i, m_idone, m_ddone;
  logic [AW-1:0] m_addr;
  logic [BW-1:0] m_we;
  logic [DW-1:0] m_din, m_irdata, m_drdata;
  int            m_dwins;   // data grants in a row while fetch was waiting
  int            n_igrant, n_dgrant, n_rst;

  task automatic model_reset();
    m_txn = 0; m_acc = 0; m_own_i = 0; m_idone = 0; m_ddone = 0;
    m_addr = '0; m_we = '0; m_din = '0; m_irdata = '0; m_drdata = '0;
    m_dwins = 0;
  endtask

  task automatic model_step();
    m_idone = 0;
    m_ddone = 0;
    if (!m_txn) begin
      if (i_req || d_req) begin
        m_own_i = i_req && (!d_req || m_dwins >= LIM);
        if (m_own_i) begin
          m_addr = i_addr; m_we = '0; m_din = '0; n_igrant++;
        end else begin
          m_addr = d_addr; m_we = d_we; m_din = d_wdata; n_dgrant++;
        end
        m_dwins = (!m_own_i && i_req) ? ((m_dwins >= LIM) ? LIM : m_dwins + 1) : 0;
        m_txn = 1;
        m_acc = 0;
      end
    end else if (!m_acc) begin
      if (mem_req_ready) m_acc = 1;
    end else if (mem_resp_valid) begin
      if (m_own_i) begin
        m_idone = 1; m_irdata = mem_dout;
      end else begin
        m_ddone = 1;
        if (m_we == '0) m_drdata = mem_dout;
      end
      m_txn = 0;
    end
  endtask

  task automatic check_outputs();
    chk("busy", 32'(busy), 32'(m_txn));
    chk("mem_req_valid", 32'(mem_req_valid), 32'(m_txn && !m_acc));
    if (m_txn && !m_acc) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_we", 32'(mem_we), 32'(m_we));
      chk("mem_din", mem_din, m_din);
    end
    chk("i_done", 32'(i_done), 32'(m_idone));
    chk("d_done", 32'(d_done), 32'(m_ddone));
    chk("i_rdata", i_rdata, m_irdata);
    chk("d_rdata", d_rdata, m_drdata);
  endtask

  task automatic check_reset_vals();
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst mem_addr", mem_addr, 32'd0);
    chk("rst mem_we", 32'(mem_we), 32'd0);
    chk("rst mem_din", mem_din, 32'd0);
    chk("rst i_done", 32'(i_done), 32'd0);
    chk("rst d_done", 32'(d_done), 32'd0);
    chk("rst i_rdata", i_rdata, 32'd0);
    chk("rst d_rdata", d_rdata, 32'd0);
  endtask

  task automatic new_d_payload();
    d_addr  = $urandom;
    d_we    = ($urandom % 2 == 0) ? '0 : BW'($urandom);
    d_wdata = $urandom;
  endtask

  // phase 1 keeps both requesters asserted to exercise the starvation rule
  task automatic drive(input int phase);
    if (m_idone) begin
      i_req = (phase == 1) || ($urandom % 4 == 0);
      if (i_req) i_addr = $urandom;
    end else if (!i_req) begin
      if (phase == 1 || $urandom % 3 == 0) begin i_req = 1; i_addr = $urandom; end
    end else if (phase == 0 && $urandom % 16 == 0) begin
      i_req = 0;
    end

    if (m_ddone) begin
      d_req = (phase == 1) || ($urandom % 4 == 0);
      if (d_req) new_d_payload();
    end else if (!d_req) begin
      if (phase == 1 || $urandom % 2 == 0) begin d_req = 1; new_d_payload(); end
    end else if (phase == 0 && $urandom % 16 == 0) begin
      d_req = 0;
    end

    mem_req_ready  = ($urandom % 3 != 0);
    mem_resp_valid = (m_txn && m_acc) ? ($urandom % 2 == 0) : ($urandom % 8 == 0);
    mem_dout       = ($urandom % 4 == 0) ? 32'hFFFF_FFFF : $urandom;
  endtask

  // Reset while a response is pending, then present the late response after release
  task automatic do_reset();
    i_req = 0; d_req = 0; mem_req_ready = 0; mem_resp_valid = 0;
    #2 rst = 1'b0;
    model_reset();
    #1 check_reset_vals();
    @(posedge clk);
    #1 check_reset_vals();
    rst            = 1'b1;
    mem_resp_valid = 1'b1;
    mem_dout       = 32'hFFFF_FFFF;
    n_rst++;
  endtask

  initial begin
    rst = 1'b1;
    i_req = 0; d_req = 0; i_addr = '0; d_addr = '0; d_we = '0; d_wdata = '0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_dout = '0;
    n_igrant = 0; n_dgrant = 0; n_rst = 0;
    model_reset();
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_reset_vals();
    rst = 1'b1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk);
      model_step();
      #1 check_outputs();
      if (cyc >= 2600 && n_rst < 8 && m_txn && m_acc && $urandom % 4 == 0)
        do_reset();
      else
        drive((cyc >= 1500 && cyc < 2400) ? 1 : 0);
    end
    $display("grants: fetch %0d data %0d, resets %0d", n_igrant, n_dgrant, n_rst);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
